// File: rtl/fifo_wr_arb_if.sv
// Bundle between the write arbiter, its requesters and the downstream FIFO.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ-1:0]       grant_o;
  logic                  fifo_rd_i;
  logic                  fifo_empty_i;
  logic                  fifo_full_i;
  logic                  wr_en_o;
  logic [WIDTH-1:0]      data_o;
  logic [CW-1:0]         credits_o;
  logic                  overflow_o;

  modport slave (
    input  req_valid_i, req_data_i, fifo_rd_i, fifo_empty_i, fifo_full_i,
    output req_ready_o, grant_o, wr_en_o, data_o, credits_o, overflow_o
  );

  modport master (
    output req_valid_i, req_data_i, fifo_rd_i, fifo_empty_i, fifo_full_i,
    input  req_ready_o, grant_o, wr_en_o, data_o, credits_o, overflow_o
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Credit-tracked round-robin burst arbiter feeding one FIFO write port.
// Define FIFO_WR_ARB_STRICT_P0_EN to give requester 0 absolute priority.
module fifo_wr_arb #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fifo_wr_arb_if.slave    bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [PW-1:0]     r_owner, w_owner_nxt;
  logic [PW-1:0]     r_rr_ptr, w_rr_nxt, w_rr_win;
  logic [PW-1:0]     w_win;
  logic              w_found;
  logic [BW-1:0]     r_burst;
  logic              r_wr_en;
  logic [WIDTH-1:0]  r_data;
  logic [CW-1:0]     r_credits;
  logic              r_ovf;
  logic [NREQ-1:0]   w_ready;
  logic              w_acc, w_rdq, w_release, w_arb;
  int                w_idx;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Output decode: ready depends only on registered state
  always_comb begin
    w_ready   = (r_state == OWN && r_credits != '0) ? r_grant : '0;
    w_acc     = |(bus.req_valid_i & w_ready);
    w_rdq     = bus.fifo_rd_i && !bus.fifo_empty_i;
    w_release = (r_state == OWN) &&
                (!bus.req_valid_i[r_owner] ||
                 (w_acc && r_burst == BW'(MAX_BURST - 1)));
    w_arb     = (r_state == IDLE) || w_release;
  end

  // Winner search; the pointer records who should be looked at first next time
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_rr_win = r_rr_ptr;
    w_idx    = 0;
`ifdef FIFO_WR_ARB_STRICT_P0_EN
    if (bus.req_valid_i[0]) begin
      w_found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        w_idx = ((r_rr_ptr == '0) ? 1 : int'(r_rr_ptr)) + k;
        if (w_idx >= NREQ) w_idx = w_idx - (NREQ - 1);
        if (!w_found && bus.req_valid_i[w_idx]) begin
          w_found = 1'b1;
          w_win   = PW'(w_idx);
        end
      end
      w_rr_win = (w_win == PW'(NREQ - 1)) ? PW'(1) : w_win + 1'b1;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
    w_rr_win = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
`endif
  end

  // Next state: release and re-arbitration share one edge
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    if (w_arb) begin
      if (w_found) begin
        w_state_nxt        = OWN;
        w_grant_nxt        = '0;
        w_grant_nxt[w_win] = 1'b1;
        w_owner_nxt        = w_win;
        w_rr_nxt           = w_rr_win;
      end else begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    end
  end

  // Datapath, credit and error tracking
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_burst   <= '0;
      r_wr_en   <= 1'b0;
      r_data    <= '0;
      r_credits <= CW'(DEPTH);
      r_ovf     <= 1'b0;
    end else begin
      if (w_arb)      r_burst <= '0;
      else if (w_acc) r_burst <= r_burst + 1'b1;
      r_wr_en <= w_acc;
      if (w_acc) r_data <= bus.req_data_i[int'(r_owner)*WIDTH +: WIDTH];
      if (w_acc && !w_rdq)
        r_credits <= r_credits - 1'b1;
      else if (w_rdq && !w_acc && r_credits != CW'(DEPTH))
        r_credits <= r_credits + 1'b1;
      if (r_wr_en && bus.fifo_full_i) r_ovf <= 1'b1;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.grant_o     = r_grant;
  assign bus.wr_en_o     = r_wr_en;
  assign bus.data_o      = r_data;
  assign bus.credits_o   = r_credits;
  assign bus.overflow_o  = r_ovf;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: arbitration order, credits, handover,
// reset behaviour and the overflow flag, with hand-computed expectations.
module tb_fifo_wr_arb;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fifo_wr_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH)) bus ();

  fifo_wr_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH), .MAX_BURST(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [31:0] d);
    bus.req_data_i[r*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.fifo_rd_i    = 1'b0;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_full_i  = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", bus.grant_o); end
    checks++; if (bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", bus.wr_en_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.data_o); end
    checks++; if (bus.credits_o !== 5'd16) begin errors++; $display("FAIL rst_credits got %0d exp 16", bus.credits_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.overflow_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", bus.req_ready_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, 32'hD000_0000 | i);
    bus.req_valid_i = 4'b1111;
    for (int e = 1; e <= 16; e++) begin
      tick();
`ifdef FIFO_WR_ARB_STRICT_P0_EN
      exp_g = 4'b0001;
      exp_d = 32'hD000_0000;
`else
      exp_g = 4'b0001 << ((e - 1) / 4);
      exp_d = 32'hD000_0000 | ((e - 2) / 4);
`endif
      checks++; if (bus.grant_o !== exp_g) begin errors++; $display("FAIL rr_grant edge %0d got %b exp %b", e, bus.grant_o, exp_g); end
      if (e >= 2) begin
        checks++; if (bus.wr_en_o !== 1'b1 || bus.data_o !== exp_d) begin errors++; $display("FAIL rr_write edge %0d got %b/%h exp 1/%h", e, bus.wr_en_o, bus.data_o, exp_d); end
      end
    end
    checks++; if (bus.credits_o !== 5'd1) begin errors++; $display("FAIL rr_credits got %0d exp 1", bus.credits_o); end
  endtask

  task automatic test_credit_exhaust();
    int nwr;
    do_reset();
    set_data(2, 32'h0000_2222);
    bus.req_valid_i = 4'b0100;
    nwr = 0;
    repeat (22) begin
      tick();
      if (bus.wr_en_o === 1'b1) nwr++;
    end
    checks++; if (nwr != 16) begin errors++; $display("FAIL cr_writes got %0d exp 16", nwr); end
    checks++; if (bus.credits_o !== 5'd0) begin errors++; $display("FAIL cr_zero got %0d exp 0", bus.credits_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL cr_ready got %b exp 0000", bus.req_ready_o); end
    checks++; if (bus.grant_o !== 4'b0100) begin errors++; $display("FAIL cr_grant got %b exp 0100", bus.grant_o); end
    bus.fifo_rd_i    = 1'b1;
    bus.fifo_empty_i = 1'b0;
    set_data(2, 32'h0000_BEEF);
    tick();
    bus.fifo_rd_i = 1'b0;
    checks++; if (bus.credits_o !== 5'd1 || bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL cr_read got %0d/%b exp 1/0100", bus.credits_o, bus.req_ready_o); end
    tick();
    checks++; if (bus.wr_en_o !== 1'b1 || bus.data_o !== 32'h0000_BEEF || bus.credits_o !== 5'd0) begin
      errors++; $display("FAIL cr_rewrite got %b/%h/%0d exp 1/0000beef/0", bus.wr_en_o, bus.data_o, bus.credits_o); end
    tick();
    checks++; if (bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL cr_stall got %b exp 0", bus.wr_en_o); end
  endtask

  task automatic test_credit_balance();
    do_reset();
    bus.req_valid_i = 4'b0010;
    repeat (12) tick();
    checks++; if (bus.credits_o !== 5'd5) begin errors++; $display("FAIL bal_setup got %0d exp 5", bus.credits_o); end
    bus.fifo_rd_i    = 1'b1;
    bus.fifo_empty_i = 1'b0;
    tick();
    checks++; if (bus.credits_o !== 5'd5 || bus.wr_en_o !== 1'b1) begin errors++; $display("FAIL bal_both got %0d/%b exp 5/1", bus.credits_o, bus.wr_en_o); end
    bus.req_valid_i  = 4'b0000;
    bus.fifo_empty_i = 1'b1;
    tick();
    checks++; if (bus.credits_o !== 5'd5) begin errors++; $display("FAIL bal_empty_rd got %0d exp 5", bus.credits_o); end
    bus.fifo_empty_i = 1'b0;
    tick();
    bus.fifo_rd_i = 1'b0;
    checks++; if (bus.credits_o !== 5'd6) begin errors++; $display("FAIL bal_read got %0d exp 6", bus.credits_o); end
  endtask

  task automatic test_handover();
    logic [3:0] exp_g;
    do_reset();
    set_data(0, 32'h0000_00A0);
    set_data(3, 32'h0000_00A3);
    bus.req_valid_i = 4'b1001;
    repeat (3) tick();
    bus.req_valid_i = 4'b1000;
    tick();
    checks++; if (bus.grant_o !== 4'b1000 || bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL ho_switch got %b/%b exp 1000/0", bus.grant_o, bus.wr_en_o); end
    bus.req_valid_i = 4'b1001;
    for (int e = 5; e <= 8; e++) begin
      tick();
      exp_g = (e == 8) ? 4'b0001 : 4'b1000;
      checks++; if (bus.grant_o !== exp_g || bus.data_o !== 32'h0000_00A3) begin
        errors++; $display("FAIL ho_burst edge %0d got %b/%h exp %b/000000a3", e, bus.grant_o, bus.data_o, exp_g); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid_i = 4'b0001;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en_o !== 1'b0 || bus.credits_o !== 5'd16 || bus.grant_o !== 4'b0000) begin
      errors++; $display("FAIL rm_async got %b/%0d/%b exp 0/16/0000", bus.wr_en_o, bus.credits_o, bus.grant_o); end
    bus.req_valid_i = 4'b0000;
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (bus.wr_en_o !== 1'b0) begin errors++; $display("FAIL rm_quiet got %b exp 0", bus.wr_en_o); end
    end
    bus.req_valid_i = 4'b0001;
    tick();
    checks++; if (bus.wr_en_o !== 1'b0 || bus.grant_o !== 4'b0001) begin errors++; $display("FAIL rm_grant got %b/%b exp 0/0001", bus.wr_en_o, bus.grant_o); end
    tick();
    checks++; if (bus.wr_en_o !== 1'b1) begin errors++; $display("FAIL rm_write got %b exp 1", bus.wr_en_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.req_valid_i = 4'b0001;
    repeat (2) tick();
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ov_pre got %b exp 0", bus.overflow_o); end
    bus.fifo_full_i = 1'b1;
    tick();
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ov_set got %b exp 1", bus.overflow_o); end
    bus.fifo_full_i = 1'b0;
    bus.req_valid_i = 4'b0000;
    repeat (4) tick();
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ov_sticky got %b exp 1", bus.overflow_o); end
  endtask

  task automatic test_rewin();
    logic [3:0] exp_g;
    do_reset();
    bus.req_valid_i = 4'b1111;
    repeat (5) tick();
`ifdef FIFO_WR_ARB_STRICT_P0_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b0010;
`endif
    checks++; if (bus.grant_o !== exp_g) begin errors++; $display("FAIL rewin got %b exp %b", bus.grant_o, exp_g); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_credit_balance();
    test_handover();
    test_reset_mid();
    test_overflow();
    test_rewin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
